// File: rtl/hms_seg7_pkg.sv
// rtl/hms_seg7_pkg.sv - shared types, limits, segment codes and BCD step for hms_seg7_scan
package hms_seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 6;
    localparam logic [3:0] DASH       = 4'hA;
    localparam logic [7:0] HH_MAX     = 8'd23;
    localparam logic [7:0] MS_MAX     = 8'd59;

    // Logical (high-true) segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic bit_in);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj[10:0], bit_in};
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - 4-bit digit code to logical 7-segment pattern
module bcd_to_seg7
    import hms_seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Digits 0-9 and the dash marker; any other code leaves the digit dark
    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            DASH:    seg = SEG_DASH;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hms_seg7_scan.sv
// rtl/hms_seg7_scan.sv - hh:mm:ss to six-digit multiplexed 7-segment display driver
module hms_seg7_scan
    import hms_seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_en,
    output logic       busy,
    output logic       err
);

    localparam int             PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]     IDX_LAST   = 3'(NUM_DIGITS - 1);

    state_t        state;
    logic [7:0]    snap_hh, snap_mm, snap_ss;
    logic [7:0]    shreg;
    logic [11:0]   bcd;
    logic [11:0]   bcd_next;
    logic [1:0]    field;
    logic [2:0]    bit_cnt;
    logic [7:0]    res_ss, res_mm, res_hh;
    logic [23:0]   disp;
    logic [PW-1:0] presc;
    logic [2:0]    idx;

    logic          ss_bad, mm_bad, hh_bad;
    logic [7:0]    ss_pair, mm_pair, hh_pair;
    logic [3:0]    cur_code;
    logic [6:0]    seg_raw;
    logic [6:0]    seg_log;
    logic          dp_log;

    assign bcd_next = dabble_step(bcd, shreg[7]);
    assign busy     = (state != IDLE);

    // Range check works on the snapshot, so a bad field shows as dashes regardless of its BCD
    assign ss_bad  = (snap_ss > MS_MAX);
    assign mm_bad  = (snap_mm > MS_MAX);
    assign hh_bad  = (snap_hh > HH_MAX);
    assign ss_pair = ss_bad ? {DASH, DASH} : res_ss;
    assign mm_pair = mm_bad ? {DASH, DASH} : res_mm;
    assign hh_pair = hh_bad ? {DASH, DASH} : res_hh;

    // Capture/convert/commit sequencer: one shared shifter converts ss, mm, hh in turn
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            snap_hh <= '0;
            snap_mm <= '0;
            snap_ss <= '0;
            shreg   <= '0;
            bcd     <= '0;
            field   <= '0;
            bit_cnt <= '0;
            res_ss  <= '0;
            res_mm  <= '0;
            res_hh  <= '0;
            disp    <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ({hh, mm, ss} != {snap_hh, snap_mm, snap_ss}) begin
                        snap_hh <= hh;
                        snap_mm <= mm;
                        snap_ss <= ss;
                        shreg   <= ss;
                        bcd     <= '0;
                        field   <= 2'd0;
                        bit_cnt <= 3'd0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        bcd <= '0;
                        case (field)
                            2'd0: begin
                                res_ss <= bcd_next[7:0];
                                shreg  <= snap_mm;
                                field  <= 2'd1;
                            end
                            2'd1: begin
                                res_mm <= bcd_next[7:0];
                                shreg  <= snap_hh;
                                field  <= 2'd2;
                            end
                            default: begin
                                res_hh <= bcd_next[7:0];
                                state  <= COMMIT;
                            end
                        endcase
                    end else begin
                        bcd   <= bcd_next;
                        shreg <= {shreg[6:0], 1'b0};
                    end
                end
                COMMIT: begin
                    disp  <= {hh_pair, mm_pair, ss_pair};
                    err   <= ss_bad | mm_bad | hh_bad;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running scan: each digit holds for SCAN_DIV cycles, blank does not stop it
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Select the display digit for the active scan position
    always_comb begin
        cur_code = disp[3:0];
        case (idx)
            3'd0:    cur_code = disp[3:0];
            3'd1:    cur_code = disp[7:4];
            3'd2:    cur_code = disp[11:8];
            3'd3:    cur_code = disp[15:12];
            3'd4:    cur_code = disp[19:16];
            default: cur_code = disp[23:20];
        endcase
    end

    bcd_to_seg7 u_dec (
        .code (cur_code),
        .seg  (seg_raw)
    );

    // Apply blanking, separator position and pin polarity
    always_comb begin
        seg_log = blank ? SEG_OFF : seg_raw;
        dp_log  = !blank && ((idx == 3'd2) || (idx == 3'd4));
        dig_en  = blank ? 6'b000000 : (6'b000001 << idx);
        seg     = SEG_ACTIVE_LOW ? ~seg_log : seg_log;
        dp      = SEG_ACTIVE_LOW ? ~dp_log : dp_log;
    end

endmodule
